// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives the request side, the slave (the subtractor) drives status and results.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (output start, a, b, bin, input busy, done, diff, bout);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell reused LSB first over WIDTH cycles,
// under an IDLE/RUN/DONE FSM with registered busy/done/diff/bout.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q, bout_q, busy_q, done_q;

    logic             d_bit, br_d;
    logic [WIDTH-1:0] res_d;

    // Single full-subtractor cell acting on the current LSBs and the borrow flop.
    always_comb begin
        d_bit = a_q[0] ^ b_q[0] ^ br_q;
        br_d  = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_d = {d_bit, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        br_q    <= bus.bin;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_d;
                    br_q  <= br_d;
                    cnt_q <= cnt_q + 1'b1;
                    // Last bit: publish the completed result straight from the cell.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        diff_q  <= res_d;
                        bout_q  <= br_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=4): directed cases, held-start throughput,
// mid-run reset, exhaustive and random operands against an arithmetic model.
module tb_serial_subtractor;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    serial_subtractor_if #(.WIDTH(W)) bus ();
    serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {bout,diff} is the (WIDTH+1)-bit wrap of a - b - bin.
    function automatic logic [W:0] model(input int av, input int bv, input int cv);
        int r;
        r = (av - bv - cv) & ((1 << (W + 1)) - 1);
        return r[W:0];
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
    task automatic run_op(input int av, input int bv, input int cv, input string tag);
        logic [W:0]   exp;
        logic [W-1:0] old_diff;
        logic         old_bout;
        exp      = model(av, bv, cv);
        old_diff = bus.diff;
        old_bout = bus.bout;
        bus.start = 1'b1; bus.a = W'(av); bus.b = W'(bv); bus.bin = cv[0];
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
            if (i == 1) bus.start = 1'b1;  // must be ignored while running
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            chk({tag, "_nodone"}, 32'(bus.done), 32'd0);
            chk({tag, "_hold"}, 32'({bus.bout, bus.diff}), 32'({old_bout, old_diff}));
        end
        bus.start = 1'b0;
        @(negedge clk);
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_dbusy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_res"}, 32'({bus.bout, bus.diff}), 32'(exp));
        @(negedge clk);
        chk({tag, "_idle"}, 32'({bus.busy, bus.done}), 32'd0);
        chk({tag, "_keep"}, 32'({bus.bout, bus.diff}), 32'(exp));
    endtask

    initial begin
        int last_done;
        int n_done;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_res", 32'({bus.bout, bus.diff}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", 32'({bus.busy, bus.done}), 32'd0);

        // Directed cases
        run_op(7, 2, 0, "d7m2");
        run_op(2, 7, 0, "d2m7");
        run_op(0, 0, 1, "d0m0b");
        run_op(15, 15, 1, "d15m15b");

        // Start held high: a done pulse every W+2 cycles, 9-3=6 each time
        bus.start = 1'b1; bus.a = 4'd9; bus.b = 4'd3; bus.bin = 1'b0;
        last_done = -1;
        n_done = 0;
        for (int cyc = 0; cyc < 5 * (W + 2); cyc++) begin
            @(negedge clk);
            if (bus.busy) bus.a = W'($urandom);
            if (bus.done) begin
                n_done++;
                chk("held_res", 32'({bus.bout, bus.diff}), 32'(model(9, 3, 0)));
                if (last_done >= 0) chk("held_gap", 32'(cyc - last_done), 32'(W + 2));
                last_done = cyc;
                bus.a = 4'd9;
            end
        end
        chk("held_count", 32'(n_done), 32'd5);
        bus.start = 1'b0;
        for (int i = 0; i < W + 2; i++) @(negedge clk);
        chk("held_settle", 32'({bus.busy, bus.done}), 32'd0);

        // Asynchronous reset mid-run, after two bits processed
        run_op(13, 2, 0, "pre_rst");
        bus.start = 1'b1; bus.a = 4'd12; bus.b = 4'd1; bus.bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_res", 32'({bus.bout, bus.diff}), 32'd0);
        #1 rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) n_done++;
        end
        chk("arst_nodone", 32'(n_done), 32'd0);
        run_op(4, 1, 0, "post_rst");

        // Exhaustive, back to back
        for (int av = 0; av < (1 << W); av++)
            for (int bv = 0; bv < (1 << W); bv++)
                for (int cv = 0; cv < 2; cv++)
                    run_op(av, bv, cv, "exh");

        // Random operands
        for (int i = 0; i < 40; i++)
            run_op(int'($urandom_range((1 << W) - 1)), int'($urandom_range((1 << W) - 1)),
                   int'($urandom_range(1)), "rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
